// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed 8N1 UART transmitter.
package fifo_uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    // 100 MHz system clock at 115200 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DEFAULT_CNT_WIDTH    = 10;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Pop handshake between the byte FIFO head and its UART transmitter consumer.
interface fifo_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_empty;
    logic                  fifo_busy;
    logic                  fifo_pop;

    // Transmitter side: samples the head and flags, issues the pop.
    modport master (
        input  fifo_data,
        input  fifo_empty,
        input  fifo_busy,
        output fifo_pop
    );

    // FIFO side: presents the head and flags, receives the pop.
    modport slave (
        output fifo_data,
        output fifo_empty,
        output fifo_busy,
        input  fifo_pop
    );
endinterface

// File: rtl/fifo_uart_tx_baud_tick.sv
// Free-running bit-period counter with synchronous clear; tick marks the last cycle of a bit.
module uart_baud_tick
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_WIDTH    = DEFAULT_CNT_WIDTH
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_clear,
    output logic o_tick
);
    localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(CLKS_PER_BIT - 1);

    logic [CNT_WIDTH-1:0] r_count;

    assign o_tick = (r_count == LAST_COUNT);

    // Count up, wrapping to zero on the tick or on an explicit clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= {CNT_WIDTH{1'b0}};
        end else if (i_clear || o_tick) begin
            r_count <= {CNT_WIDTH{1'b0}};
        end else begin
            r_count <= r_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the FIFO head and sends each as an 8N1 UART frame, LSB first.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_WIDTH    = DEFAULT_CNT_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 tx_enable,
    fifo_uart_tx_if.master       fifo,
    output logic                 tx,
    output logic                 tx_active,
    output logic [15:0]          frames_sent
);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_WIDTH - 1);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [IDX_W-1:0]      r_bit_idx;
    logic                  r_tx;
    logic                  r_pop;
    logic                  r_active;
    logic [15:0]           r_frames_sent;
    logic                  w_tick;
    logic                  w_clear;
    logic [DATA_WIDTH-1:0] w_shift_next;

    // Hold the bit counter at zero until START so the start bit gets a full period.
    assign w_clear      = (r_state == IDLE) || (r_state == FETCH);
    assign w_shift_next = r_shift >> 1;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_baud_tick (
        .clock   (clock),
        .reset_n (reset_n),
        .i_clear (w_clear),
        .o_tick  (w_tick)
    );

    // Frame sequencer; every output is registered alongside the state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_shift       <= {DATA_WIDTH{1'b0}};
            r_bit_idx     <= {IDX_W{1'b0}};
            r_tx          <= 1'b1;
            r_pop         <= 1'b0;
            r_active      <= 1'b0;
            r_frames_sent <= 16'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (tx_enable && !fifo.fifo_empty && !fifo.fifo_busy) begin
                        r_state  <= FETCH;
                        r_pop    <= 1'b1;
                        r_active <= 1'b1;
                    end else begin
                        r_pop    <= 1'b0;
                        r_active <= 1'b0;
                    end
                end
                // The head is still valid here: the FIFO advances one cycle after sampling pop.
                FETCH: begin
                    r_shift  <= fifo.fifo_data;
                    r_pop    <= 1'b0;
                    r_tx     <= 1'b0;
                    r_active <= 1'b1;
                    r_state  <= START;
                end
                START: begin
                    if (w_tick) begin
                        r_bit_idx <= {IDX_W{1'b0}};
                        r_tx      <= r_shift[0];
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shift <= w_shift_next;
                        if (r_bit_idx == LAST_BIT) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                            r_tx      <= w_shift_next[0];
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_frames_sent <= r_frames_sent + 16'd1;
                        r_active      <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_tx     <= 1'b1;
                    r_pop    <= 1'b0;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign fifo.fifo_pop = r_pop;
    assign tx            = r_tx;
    assign tx_active     = r_active;
    assign frames_sent   = r_frames_sent;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a small FIFO model and CLKS_PER_BIT=4.
module tb_fifo_uart_tx;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        tx_enable = 1'b0;
    logic        busy_force = 1'b0;
    logic        tx;
    logic        tx_active;
    logic [15:0] frames_sent;

    logic [7:0] mem [16];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         pop_total = 0;
    int         n_checks = 0;
    int         n_pass = 0;

    fifo_uart_tx_if #(.DATA_WIDTH(8)) ifc ();

    assign ifc.fifo_data  = mem[rd_ptr[3:0]];
    assign ifc.fifo_empty = (wr_ptr == rd_ptr);
    assign ifc.fifo_busy  = busy_force;

    fifo_uart_tx #(
        .DATA_WIDTH   (8),
        .CLKS_PER_BIT (4),
        .CNT_WIDTH    (4)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .tx_enable   (tx_enable),
        .fifo        (ifc.master),
        .tx          (tx),
        .tx_active   (tx_active),
        .frames_sent (frames_sent)
    );

    always #5 clock = ~clock;

    // FIFO head advances on the edge that samples pop.
    always @(posedge clock) begin
        if (ifc.fifo_pop === 1'b1) begin
            rd_ptr    <= rd_ptr + 1;
            pop_total <= pop_total + 1;
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[3:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        tx_enable  = 1'b0;
        busy_force = 1'b0;
        wr_ptr     = rd_ptr;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic wait_tx_low(input int budget, output int waited, output bit ok);
        waited = 0;
        ok     = 1'b0;
        while (waited < budget) begin
            if (tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
            waited++;
        end
        n_checks++;
        if (!ok) $display("FAIL tx_start_timeout: tx still %b after %0d cycles", tx, waited);
        else n_pass++;
    endtask

    // Called on the first start-bit cycle; samples all 40 cycles of the frame.
    task automatic grab_frame(output logic [9:0] bits, output bit steady, input int drop_cyc);
        steady = 1'b1;
        bits   = 10'd0;
        for (int k = 0; k < 10; k++) begin
            bits[k] = tx;
            for (int j = 0; j < 4; j++) begin
                if (tx !== bits[k]) steady = 1'b0;
                if (k * 4 + j == drop_cyc) tx_enable = 1'b0;
                @(negedge clock);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        n_checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else n_pass++;
        n_checks++; if (ifc.fifo_pop !== 1'b0) $display("FAIL reset_pop: got %b want 0", ifc.fifo_pop); else n_pass++;
        n_checks++; if (tx_active !== 1'b0) $display("FAIL reset_active: got %b want 0", tx_active); else n_pass++;
        n_checks++; if (frames_sent !== 16'h0000) $display("FAIL reset_frames: got %h want 0000", frames_sent); else n_pass++;
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single_byte();
        logic [9:0] bits;
        logic [9:0] exp_bits;
        bit         steady;
        int         p0;
        do_reset();
        p0 = pop_total;
        exp_bits = 10'b1101001010;
        push(8'hA5);
        tx_enable = 1'b1;
        @(negedge clock);
        n_checks++; if (ifc.fifo_pop !== 1'b1) $display("FAIL single_pop_hi: got %b want 1", ifc.fifo_pop); else n_pass++;
        n_checks++; if (tx !== 1'b1) $display("FAIL single_tx_fetch: got %b want 1", tx); else n_pass++;
        @(negedge clock);
        n_checks++; if (ifc.fifo_pop !== 1'b0) $display("FAIL single_pop_lo: got %b want 0", ifc.fifo_pop); else n_pass++;
        n_checks++; if (tx !== 1'b0) $display("FAIL single_tx_start: got %b want 0", tx); else n_pass++;
        grab_frame(bits, steady, -1);
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (bits[k] !== exp_bits[k]) $display("FAIL single_bit%0d: got %b want %b", k, bits[k], exp_bits[k]);
            else n_pass++;
        end
        n_checks++; if (steady !== 1'b1) $display("FAIL single_bit_width: bits not held 4 cycles"); else n_pass++;
        n_checks++; if (frames_sent !== 16'd1) $display("FAIL single_frames: got %0d want 1", frames_sent); else n_pass++;
        n_checks++; if (pop_total - p0 !== 1) $display("FAIL single_pops: got %0d want 1", pop_total - p0); else n_pass++;
        n_checks++; if (tx_active !== 1'b0) $display("FAIL single_active_end: got %b want 0", tx_active); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_bytes [3];
        logic [9:0] bits;
        bit         steady;
        bit         ok;
        int         waited;
        int         p0;
        exp_bytes[0] = 8'h00;
        exp_bytes[1] = 8'hFF;
        exp_bytes[2] = 8'h3C;
        do_reset();
        p0 = pop_total;
        for (int i = 0; i < 3; i++) push(exp_bytes[i]);
        tx_enable = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_tx_low(20, waited, ok);
            if (f > 0) begin
                n_checks++;
                if (4 + waited !== 6) $display("FAIL b2b_gap%0d: got %0d high cycles want 6", f, 4 + waited);
                else n_pass++;
            end
            grab_frame(bits, steady, -1);
            n_checks++;
            if (bits !== {1'b1, exp_bytes[f], 1'b0}) $display("FAIL b2b_frame%0d: got %b want %b", f, bits, {1'b1, exp_bytes[f], 1'b0});
            else n_pass++;
            n_checks++; if (steady !== 1'b1) $display("FAIL b2b_width%0d: bits not held 4 cycles", f); else n_pass++;
        end
        repeat (10) @(negedge clock);
        n_checks++; if (pop_total - p0 !== 3) $display("FAIL b2b_pops: got %0d want 3", pop_total - p0); else n_pass++;
        n_checks++; if (frames_sent !== 16'd3) $display("FAIL b2b_frames: got %0d want 3", frames_sent); else n_pass++;
        n_checks++; if (tx_active !== 1'b0) $display("FAIL b2b_active_idle: got %b want 0", tx_active); else n_pass++;
        n_checks++; if (tx !== 1'b1) $display("FAIL b2b_tx_idle: got %b want 1", tx); else n_pass++;
    endtask

    task automatic test_busy_hold();
        logic [9:0] bits;
        bit         steady;
        int         bad;
        int         p0;
        do_reset();
        p0 = pop_total;
        busy_force = 1'b1;
        push(8'h5A);
        tx_enable = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clock);
            if (ifc.fifo_pop !== 1'b0 || tx !== 1'b1) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL busy_hold: got %0d bad cycles want 0", bad); else n_pass++;
        n_checks++; if (pop_total - p0 !== 0) $display("FAIL busy_pops: got %0d want 0", pop_total - p0); else n_pass++;
        busy_force = 1'b0;
        @(negedge clock);
        n_checks++; if (ifc.fifo_pop !== 1'b1) $display("FAIL busy_release_pop: got %b want 1", ifc.fifo_pop); else n_pass++;
        @(negedge clock);
        n_checks++; if (tx !== 1'b0) $display("FAIL busy_start: got %b want 0", tx); else n_pass++;
        grab_frame(bits, steady, -1);
        n_checks++; if (bits !== 10'b1010110100) $display("FAIL busy_frame: got %b want 1010110100", bits); else n_pass++;
    endtask

    task automatic test_enable_drop();
        logic [9:0] bits;
        bit         steady;
        bit         ok;
        int         waited;
        int         p0;
        do_reset();
        p0 = pop_total;
        push(8'h96);
        push(8'h11);
        tx_enable = 1'b1;
        wait_tx_low(20, waited, ok);
        grab_frame(bits, steady, 17);
        n_checks++; if (bits !== 10'b1100101100) $display("FAIL endrop_frame: got %b want 1100101100", bits); else n_pass++;
        n_checks++; if (steady !== 1'b1) $display("FAIL endrop_width: bits not held 4 cycles"); else n_pass++;
        repeat (20) @(negedge clock);
        n_checks++; if (pop_total - p0 !== 1) $display("FAIL endrop_pops: got %0d want 1", pop_total - p0); else n_pass++;
        n_checks++; if (tx_active !== 1'b0) $display("FAIL endrop_active: got %b want 0", tx_active); else n_pass++;
        n_checks++; if (frames_sent !== 16'd1) $display("FAIL endrop_frames: got %0d want 1", frames_sent); else n_pass++;
        n_checks++; if (tx !== 1'b1) $display("FAIL endrop_tx: got %b want 1", tx); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] bits;
        bit         steady;
        bit         ok;
        int         waited;
        do_reset();
        push(8'h81);
        push(8'hC3);
        push(8'h7E);
        tx_enable = 1'b1;
        wait_tx_low(20, waited, ok);
        grab_frame(bits, steady, -1);
        n_checks++; if (frames_sent !== 16'd1) $display("FAIL rst_pre_frames: got %0d want 1", frames_sent); else n_pass++;
        wait_tx_low(20, waited, ok);
        repeat (25) @(negedge clock);
        reset_n = 1'b0;
        #1;
        n_checks++; if (tx !== 1'b1) $display("FAIL rst_mid_tx: got %b want 1", tx); else n_pass++;
        n_checks++; if (ifc.fifo_pop !== 1'b0) $display("FAIL rst_mid_pop: got %b want 0", ifc.fifo_pop); else n_pass++;
        n_checks++; if (frames_sent !== 16'd0) $display("FAIL rst_mid_frames: got %0d want 0", frames_sent); else n_pass++;
        n_checks++; if (tx_active !== 1'b0) $display("FAIL rst_mid_active: got %b want 0", tx_active); else n_pass++;
        @(negedge clock);
        reset_n = 1'b1;
        wait_tx_low(20, waited, ok);
        grab_frame(bits, steady, -1);
        n_checks++; if (bits !== 10'b1011111100) $display("FAIL rst_new_frame: got %b want 1011111100", bits); else n_pass++;
        n_checks++; if (frames_sent !== 16'd1) $display("FAIL rst_post_frames: got %0d want 1", frames_sent); else n_pass++;
    endtask

    task automatic test_frame_wrap();
        logic [9:0] bits;
        bit         steady;
        bit         ok;
        int         waited;
        do_reset();
        force dut.r_frames_sent = 16'hFFFF;
        @(negedge clock);
        release dut.r_frames_sent;
        @(negedge clock);
        n_checks++; if (frames_sent !== 16'hFFFF) $display("FAIL wrap_preload: got %h want ffff", frames_sent); else n_pass++;
        push(8'h42);
        tx_enable = 1'b1;
        wait_tx_low(20, waited, ok);
        grab_frame(bits, steady, -1);
        n_checks++; if (bits !== 10'b1010000100) $display("FAIL wrap_frame: got %b want 1010000100", bits); else n_pass++;
        n_checks++; if (frames_sent !== 16'h0000) $display("FAIL wrap_count: got %h want 0000", frames_sent); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_busy_hold();
        test_enable_drop();
        test_reset_mid_frame();
        test_frame_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
